// File: rtl/boxhead_soc_led_if.sv
// Avalon-MM slave bus bundle for the BoxHead LED output PIO.
interface boxhead_soc_led_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/boxhead_soc_led.sv
// Avalon-MM output PIO: data register with atomic set/clear and optional timed pulse.
// Optional pulse feature enabled by defining BOXHEAD_LED_PULSE_EN.
module boxhead_soc_led #(
    parameter int unsigned          WIDTH        = 8,
    parameter logic [WIDTH-1:0]     RESET_VALUE  = '0,
    parameter logic [31:0]          PULSE_CYCLES = 32'd50000000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    boxhead_soc_led_if.slave     avs,
    output logic [WIDTH-1:0]     out_port
);

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data, data_nx;
    logic             unused_wd;

    assign wr        = avs.chipselect & ~avs.write_n;
    assign wd        = avs.writedata[WIDTH-1:0];
    assign unused_wd = ^avs.writedata;
    assign out_port  = data;

`ifdef BOXHEAD_LED_PULSE_EN
    logic [WIDTH-1:0] armed, armed_nx;
    logic [31:0]      counter, counter_nx;
`endif

    // Expiry is applied first, then the bus write overrides it on the same edge.
    always_comb begin
        data_nx    = data;
`ifdef BOXHEAD_LED_PULSE_EN
        armed_nx   = armed;
        counter_nx = counter;
        if (armed != '0) begin
            if (counter == '0) begin
                data_nx  = data & ~armed;
                armed_nx = '0;
            end else begin
                counter_nx = counter - 32'd1;
            end
        end
`endif
        if (wr) begin
            case (avs.address)
                2'd0: begin
                    data_nx  = wd;
`ifdef BOXHEAD_LED_PULSE_EN
                    armed_nx = '0;
`endif
                end
                2'd1: begin
`ifdef BOXHEAD_LED_PULSE_EN
                    data_nx    = data_nx | wd;
                    armed_nx   = armed_nx | wd;
                    counter_nx = PULSE_CYCLES - 32'd1;
`endif
                end
                2'd2: begin
                    data_nx  = data_nx | wd;
`ifdef BOXHEAD_LED_PULSE_EN
                    armed_nx = armed_nx & ~wd;
`endif
                end
                default: begin
                    data_nx  = data_nx & ~wd;
`ifdef BOXHEAD_LED_PULSE_EN
                    armed_nx = armed_nx & ~wd;
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data <= RESET_VALUE;
`ifdef BOXHEAD_LED_PULSE_EN
            armed   <= '0;
            counter <= '0;
`endif
        end else begin
            data <= data_nx;
`ifdef BOXHEAD_LED_PULSE_EN
            armed   <= armed_nx;
            counter <= counter_nx;
`endif
        end
    end

    // Read mux samples pre-write state, so a concurrent write is not visible yet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs.readdata <= '0;
        end else begin
            case (avs.address)
                2'd0:    avs.readdata <= 32'(data);
`ifdef BOXHEAD_LED_PULSE_EN
                2'd1:    avs.readdata <= 32'(armed);
`endif
                default: avs.readdata <= '0;
            endcase
        end
    end

endmodule
